hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Parametrised load-use hazard and pipeline-control unit for the 5-stage pipeline. It sits between the ID and EX stage registers and drives the IF/ID hold, the ID/EX bubble, the branch flush and the whole-pipeline freeze. Compared with the single-cycle load-use detector it replaces, it adds:
- a configurable multi-cycle load-use stall, sequenced by a small FSM;
- per-operand use qualification and register-0 exemption;
- a memory-busy freeze and branch-flush arbitration;
- a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- REG_AW, 5, register-address width
- LOAD_LAT, 1, load-use stall cycles per hazard (legal 1..8)
- CNT_W, 16, width of Stall_Cnt
- ZERO_REG, 1, 1 = register 0 never creates a hazard

Ports (one clock; reset is synchronous and active-low):
- Clk  in  1  clock, all state updates on rising edge
- Rst_n  in  1  synchronous active-low reset
- MemRead_EX  in  1  EX-stage instruction is a load
- RegWrite_EX  in  1  EX-stage instruction writes a register
- Rd_EX  in  REG_AW  EX-stage destination register
- Rs_ID  in  REG_AW  ID-stage source register 1
- Rt_ID  in  REG_AW  ID-stage source register 2
- UsesRs_ID  in  1  ID instruction reads Rs
- UsesRt_ID  in  1  ID instruction reads Rt
- Branch_Taken_EX  in  1  taken branch resolved in EX
- Mem_Busy  in  1  data memory not ready; whole pipeline must hold
- Stall  out  1  hold PC and IF/ID
- Bubble_EX  out  1  zero ID/EX control fields at next edge
- Flush  out  1  squash IF/ID and ID/EX contents
- Freeze  out  1  hold every stage register, no bubbles
- Stall_Cnt  out  CNT_W  saturating count of cycles with Stall=1

## Operation
- Hazard term H = MemRead_EX & RegWrite_EX & ~(ZERO_REG & Rd_EX==0) & ((UsesRs_ID & Rs_ID==Rd_EX) | (UsesRt_ID & Rt_ID==Rd_EX)).
- FSM states:
  - IDLE
  - LSTALL: the remaining stall cycles are held in a 3-bit register Rem.
- Priority, highest first: reset, Mem_Busy, Branch_Taken_EX, load-use stall.
- Mem_Busy=1:
  - Freeze=1; Stall=0, Bubble_EX=0, Flush=0.
  - State, Rem and Stall_Cnt hold.
- Branch_Taken_EX=1 with Mem_Busy=0:
  - Flush=1, Bubble_EX=1, Stall=0.
  - In LSTALL, the next state is IDLE (the stalled instruction is squashed).
- IDLE, H=1, no freeze/flush:
  - Stall=1, Bubble_EX=1.
  - If LOAD_LAT>1, next state LSTALL with Rem=LOAD_LAT-1; else stay IDLE.
- LSTALL, no freeze/flush:
  - Stall=1, Bubble_EX=1 regardless of H (EX now holds a bubble).
  - Rem decrements; when Rem==1, next state IDLE.
- IDLE, H=0: all control outputs 0.
- Stall_Cnt increments by 1 on every edge where Stall=1 and sticks at 2^CNT_W-1.
- Illegal LOAD_LAT (0 or >8) is a parameter error: the RTL must fail elaboration.

## Timing
- Stall, Bubble_EX, Flush and Freeze are combinational from state plus current inputs, valid before the edge that captures into IF/ID and ID/EX. Detection latency is 0 cycles.
- One load-use hazard produces exactly LOAD_LAT consecutive non-frozen cycles with Stall=1. Freeze cycles in between extend the wall-clock time but not the count.
- Reset (Rst_n=0 at an edge):
  - state IDLE, Rem=0, Stall_Cnt=0.
  - While Rst_n=0, all four control outputs are forced to 0.
  - Reset mid-LSTALL aborts the stall; no residual stall cycle occurs after release.
- Back-to-back hazards: a new H in the cycle after LSTALL returns to IDLE starts a fresh LOAD_LAT sequence with no gap cycle.
- Mem_Busy and Branch_Taken_EX asserted together: only Freeze=1. The flush is taken on the first cycle after Mem_Busy falls, provided Branch_Taken_EX is still high.

## Test plan
- LOAD_LAT=1: MemRead_EX=1, RegWrite_EX=1, Rd_EX=5, Rs_ID=5, UsesRs_ID=1 for one cycle -> Stall=1 and Bubble_EX=1 in that cycle only; Stall_Cnt goes 0->1.
- LOAD_LAT=3: same hazard, EX cleared after the first edge -> Stall=1 for exactly 3 cycles (IDLE, LSTALL Rem=2, Rem=1), then IDLE; Stall_Cnt=3.
- Qualification: Rd_EX=0 with ZERO_REG=1, Rt_ID=0, UsesRt_ID=1 -> Stall=0. Rd_EX=7, Rt_ID=7, UsesRt_ID=0 -> Stall=0. RegWrite_EX=0 -> Stall=0.
- LOAD_LAT=3: Mem_Busy=1 for 2 cycles during LSTALL Rem=2 -> Freeze=1, Stall=0, Rem held at 2. After release, Stall=1 for 2 more cycles; total stall cycles = 3.
- LSTALL Rem=2 with Branch_Taken_EX=1 -> Flush=1, Bubble_EX=1, Stall=0, next state IDLE. With Mem_Busy=1 in the same cycle -> Freeze=1 only; Flush=1 on the cycle after Mem_Busy drops.
- CNT_W=4: hold hazard sequences for 20 stall cycles -> Stall_Cnt saturates at 15. Rst_n=0 mid-LSTALL -> outputs 0 immediately, Stall_Cnt=0 and state IDLE after the edge.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Load-use hazard and pipeline-control unit: multi-cycle load-use stall FSM,
// memory-busy freeze, branch-flush arbitration and a saturating stall counter.
module hazard_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              MemRead_EX,
  input  logic              RegWrite_EX,
  input  logic [REG_AW-1:0] Rd_EX,
  input  logic [REG_AW-1:0] Rs_ID,
  input  logic [REG_AW-1:0] Rt_ID,
  input  logic              UsesRs_ID,
  input  logic              UsesRt_ID,
  input  logic              Branch_Taken_EX,
  input  logic              Mem_Busy,
  output logic              Stall,
  output logic              Bubble_EX,
  output logic              Flush,
  output logic              Freeze,
  output logic [CNT_W-1:0]  Stall_Cnt
);

  if (LOAD_LAT < 1 || LOAD_LAT > 8) begin : g_badLoadLat
    $error("hazard_ctrl_unit: LOAD_LAT must be in the range 1..8");
  end

  typedef enum logic {
    IDLE,
    LSTALL
  } state_t;

  localparam logic [2:0]       REM_INIT   = 3'(LOAD_LAT - 1);
  localparam bit               MULTI_STAL = (LOAD_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t            r_state;
  state_t            w_nextState;
  logic [2:0]        r_rem;
  logic [2:0]        w_nextRem;
  logic [CNT_W-1:0]  r_stallCnt;

  logic w_rdExempt;
  logic w_rsMatch;
  logic w_rtMatch;
  logic w_hazard;
  logic w_stall;
  logic w_bubble;
  logic w_flush;
  logic w_freeze;

  assign w_rdExempt = (ZERO_REG != 0) && (Rd_EX == '0);
  assign w_rsMatch  = UsesRs_ID && (Rs_ID == Rd_EX);
  assign w_rtMatch  = UsesRt_ID && (Rt_ID == Rd_EX);
  assign w_hazard   = MemRead_EX && RegWrite_EX && !w_rdExempt && (w_rsMatch || w_rtMatch);

  // Freeze outranks flush, which outranks the load-use stall; freeze holds all state.
  always_comb begin
    w_nextState = r_state;
    w_nextRem   = r_rem;
    w_stall     = 1'b0;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    w_freeze    = 1'b0;
    if (!Rst_n) begin
      w_nextState = IDLE;
      w_nextRem   = 3'd0;
    end else if (Mem_Busy) begin
      w_freeze = 1'b1;
    end else if (Branch_Taken_EX) begin
      w_flush     = 1'b1;
      w_bubble    = 1'b1;
      w_nextState = IDLE;
      w_nextRem   = 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hazard) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
            if (MULTI_STAL) begin
              w_nextState = LSTALL;
              w_nextRem   = REM_INIT;
            end
          end
        end
        LSTALL: begin
          w_stall   = 1'b1;
          w_bubble  = 1'b1;
          w_nextRem = r_rem - 3'd1;
          if (r_rem <= 3'd1) begin
            w_nextState = IDLE;
            w_nextRem   = 3'd0;
          end
        end
        default: begin
          w_nextState = IDLE;
          w_nextRem   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= IDLE;
      r_rem   <= 3'd0;
    end else begin
      r_state <= w_nextState;
      r_rem   <= w_nextRem;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_stallCnt <= '0;
    end else if (w_stall && (r_stallCnt != CNT_MAX)) begin
      r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

  assign Stall     = w_stall;
  assign Bubble_EX = w_bubble;
  assign Flush     = w_flush;
  assign Freeze    = w_freeze;
  assign Stall_Cnt = r_stallCnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench: a LOAD_LAT=1 instance driven from a vector table, and a
// LOAD_LAT=3 / CNT_W=4 instance exercised with hand-written multi-cycle sequences.
module tb_hazard_ctrl_unit;

  typedef struct {
    logic       memRead;
    logic       regWrite;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRs;
    logic       usesRt;
    logic       branch;
    logic       memBusy;
    logic [3:0] exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstNA, rstNB;
  logic       memRead, regWrite, usesRs, usesRt, branch, memBusy;
  logic [4:0] rd, rs, rt;

  logic        stallA, bubbleA, flushA, freezeA;
  logic        stallB, bubbleB, flushB, freezeB;
  logic [3:0]  cntA;
  logic [15:0] cntB;
  logic [3:0]  ctrlA, ctrlB;

  int checks = 0;
  int errors = 0;
  int expCntA = 0;
  int expCntB = 0;

  vec_t vecs[14];

  assign ctrlA = {stallA, bubbleA, flushA, freezeA};
  assign ctrlB = {stallB, bubbleB, flushB, freezeB};

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4), .ZERO_REG(1)) dutA (
    .Clk(clk), .Rst_n(rstNA), .MemRead_EX(memRead), .RegWrite_EX(regWrite),
    .Rd_EX(rd), .Rs_ID(rs), .Rt_ID(rt), .UsesRs_ID(usesRs), .UsesRt_ID(usesRt),
    .Branch_Taken_EX(branch), .Mem_Busy(memBusy), .Stall(stallA), .Bubble_EX(bubbleA),
    .Flush(flushA), .Freeze(freezeA), .Stall_Cnt(cntA)
  );

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16), .ZERO_REG(1)) dutB (
    .Clk(clk), .Rst_n(rstNB), .MemRead_EX(memRead), .RegWrite_EX(regWrite),
    .Rd_EX(rd), .Rs_ID(rs), .Rt_ID(rt), .UsesRs_ID(usesRs), .UsesRt_ID(usesRt),
    .Branch_Taken_EX(branch), .Mem_Busy(memBusy), .Stall(stallB), .Bubble_EX(bubbleB),
    .Flush(flushB), .Freeze(freezeB), .Stall_Cnt(cntB)
  );

  function automatic vec_t mk(input logic mr, input logic rw, input int d, input int s,
                              input int t, input logic ur, input logic ut, input logic br,
                              input logic mb, input logic [3:0] e, input string n);
    vec_t v;
    v.memRead = mr; v.regWrite = rw;
    v.rd = 5'(d); v.rs = 5'(s); v.rt = 5'(t);
    v.usesRs = ur; v.usesRt = ut; v.branch = br; v.memBusy = mb;
    v.exp = e; v.name = n;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    memRead = v.memRead; regWrite = v.regWrite;
    rd = v.rd; rs = v.rs; rt = v.rt;
    usesRs = v.usesRs; usesRt = v.usesRt;
    branch = v.branch; memBusy = v.memBusy;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic setLoadHazard();
    applyStimulus(mk(1, 1, 5, 5, 0, 1, 0, 0, 0, 4'b0000, ""));
  endtask

  task automatic clearInputs();
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, ""));
  endtask

  // Called just after a falling edge with inputs set; checks control, then counter.
  task automatic cycleA(input string name, input logic [3:0] expCtrl);
    #1;
    checkOutput(name, 16'(ctrlA), 16'(expCtrl));
    if (expCtrl[3] && expCntA != 15) expCntA++;
    @(posedge clk);
    #1;
    checkOutput({name, "_cnt"}, 16'(cntA), 16'(expCntA));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // {stall, bubble, flush, freeze}
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "allZero");
    vecs[1]  = mk(1, 1, 5, 5, 0, 1, 0, 0, 0, 4'b1100, "rsHazard");
    vecs[2]  = mk(1, 1, 7, 0, 7, 0, 1, 0, 0, 4'b1100, "rtHazard");
    vecs[3]  = mk(1, 1, 7, 0, 7, 0, 0, 0, 0, 4'b0000, "rtUnused");
    vecs[4]  = mk(1, 1, 0, 0, 0, 1, 1, 0, 0, 4'b0000, "zeroReg");
    vecs[5]  = mk(1, 0, 5, 5, 0, 1, 0, 0, 0, 4'b0000, "noRegWrite");
    vecs[6]  = mk(0, 1, 5, 5, 0, 1, 0, 0, 0, 4'b0000, "noLoad");
    vecs[7]  = mk(1, 1, 5, 5, 0, 1, 0, 1, 0, 4'b0110, "hazardBranch");
    vecs[8]  = mk(1, 1, 5, 5, 0, 1, 0, 0, 1, 4'b0001, "hazardBusy");
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0001, "branchBusy");
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0110, "branchOnly");
    vecs[11] = mk(1, 1, 5, 3, 5, 1, 1, 0, 0, 4'b1100, "rtMatchRsMiss");
    vecs[12] = mk(1, 1, 31, 31, 0, 1, 0, 0, 0, 4'b1100, "reg31");
    vecs[13] = mk(1, 1, 6, 5, 4, 1, 1, 0, 0, 4'b0000, "noMatch");

    rstNA = 1'b0;
    rstNB = 1'b0;
    clearInputs();
    @(negedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rstCntA", 16'(cntA), 16'd0);
    checkOutput("rstCntB", cntB, 16'd0);
    checkOutput("rstCtrlB", 16'(ctrlB), 16'd0);
    @(negedge clk);

    // dutA stays in reset: its outputs must stay 0 even while the table shows hazards.
    rstNB = 1'b1;
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i].name, 16'(ctrlB), 16'(vecs[i].exp));
      checkOutput({vecs[i].name, "_rstA"}, 16'(ctrlA), 16'd0);
      if (vecs[i].exp[3]) expCntB++;
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, "_cnt"}, cntB, 16'(expCntB));
      @(negedge clk);
    end
    checkOutput("rstHeldCntA", 16'(cntA), 16'd0);

    rstNA = 1'b1;
    clearInputs();
    expCntA = 0;
    cycleA("idleAfterRst", 4'b0000);

    // Plain three-cycle load-use stall.
    setLoadHazard();
    cycleA("ll3_c0", 4'b1100);
    clearInputs();
    cycleA("ll3_c1", 4'b1100);
    cycleA("ll3_c2", 4'b1100);
    cycleA("ll3_idle", 4'b0000);

    // Freeze in the middle of the stall must not consume stall cycles.
    setLoadHazard();
    cycleA("frz_c0", 4'b1100);
    clearInputs();
    memBusy = 1'b1;
    cycleA("frz_busy0", 4'b0001);
    cycleA("frz_busy1", 4'b0001);
    memBusy = 1'b0;
    cycleA("frz_c1", 4'b1100);
    cycleA("frz_c2", 4'b1100);
    cycleA("frz_idle", 4'b0000);

    // Branch during the stall: freeze wins first, then flush, then back to idle.
    setLoadHazard();
    cycleA("br_c0", 4'b1100);
    clearInputs();
    branch  = 1'b1;
    memBusy = 1'b1;
    cycleA("br_busy", 4'b0001);
    memBusy = 1'b0;
    cycleA("br_flush", 4'b0110);
    branch = 1'b0;
    cycleA("br_idle", 4'b0000);

    // Continuous hazard: back-to-back sequences with no gap, counter saturates at 15.
    setLoadHazard();
    for (int k = 0; k < 22; k++) begin
      cycleA($sformatf("b2b_%0d", k), 4'b1100);
    end
    checkOutput("satCnt", 16'(cntA), 16'd15);

    // Reset while in LSTALL with the hazard still present.
    rstNA = 1'b0;
    #1;
    checkOutput("midRstCtrl", 16'(ctrlA), 16'd0);
    @(posedge clk);
    #1;
    expCntA = 0;
    checkOutput("midRstCnt", 16'(cntA), 16'(expCntA));
    @(negedge clk);
    rstNA = 1'b1;
    clearInputs();
    cycleA("postRstNoResidual", 4'b0000);
    setLoadHazard();
    cycleA("postRstHazard", 4'b1100);
    clearInputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
